mii_rx_byte_assembler: RTL and testbench

Upstream stage of the UDP receive path for the 100M port. Runs on the PHY receive clock and turns the 4-bit MII/RGMII-SDR nibble stream into bytes, low nibble first. It strips preamble and SFD and marks frame start and end. It flags dribble, overlength and preamble errors, and keeps frame and error counters. Its byte stream feeds the UDP/IP receive parser, which then writes payload into the dual-port RAM.

---
 rtl/eth_rx_pkg.sv | 38 +++
 rtl/crc32_d8.sv | 22 ++
 rtl/mii_rx_byte_assembler.sv | 205 ++++++++++++++++++++
 tb/tb_mii_rx_byte_assembler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the MII receive byte assembler.
package eth_rx_pkg;

  typedef enum logic [2:0] {IDLE, PRE, LO, HI, EOF, DROP} state_t;

  localparam int unsigned NIB_W     = 4;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned LEN_W     = 16;
  localparam int unsigned PRE_CNT_W = 4;
  localparam int unsigned CRC_W     = 32;

  localparam logic [NIB_W-1:0] PRE_NIBBLE      = 4'h5;
  localparam logic [NIB_W-1:0] SFD_NIBBLE      = 4'hD;
  localparam logic [CRC_W-1:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [CRC_W-1:0] CRC32_RESIDUE   = 32'hC704DD7B;
  localparam logic [CRC_W-1:0] CRC32_POLY_REFL = 32'hEDB88320;

  // Reflected CRC-32 advanced by one byte, LSB first.
  function automatic logic [CRC_W-1:0] crc32_next(input logic [CRC_W-1:0] crc,
                                                  input logic [BYTE_W-1:0] data);
    logic [CRC_W-1:0] c;
    c = crc ^ CRC_W'(data);
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

  // The residue constant is in MSB-first form; the register is LSB first.
  function automatic logic [CRC_W-1:0] bitrev32(input logic [CRC_W-1:0] x);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = x[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide CRC-32 accumulator used for FCS checking.
module crc32_d8
  import eth_rx_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [BYTE_W-1:0] data,
  output logic [CRC_W-1:0]  crc
);

  // Restart on clear, otherwise fold in each enabled byte.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      crc <= CRC32_INIT;
    end else if (en) begin
      crc <= crc32_next(crc, data);
    end
  end

endmodule

// File: rtl/mii_rx_byte_assembler.sv
// MII nibble-to-byte assembler: strips preamble/SFD, marks sof/eof,
// flags dribble/overlength/preamble errors and counts frames.
// Optional FCS check enabled by defining ETH_RX_FCS_CHECK_EN.
module mii_rx_byte_assembler
  import eth_rx_pkg::*;
#(
  parameter int unsigned MIN_PRE_NIBBLES = 8,
  parameter int unsigned MAX_FRAME_BYTES = 1518,
  parameter int unsigned CNT_W           = 16
) (
  input  logic              e_rxc,
  input  logic              reset,
  input  logic              e_rxdv,
  input  logic [NIB_W-1:0]  e_rxd,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid,
  output logic              sof,
  output logic              eof,
  output logic              frame_err,
  output logic [LEN_W-1:0]  frame_len,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  state_t                 state, state_d;
  logic                   rxdv_q;
  logic [NIB_W-1:0]       rxd_q;
  logic [PRE_CNT_W-1:0]   pre_cnt, pre_cnt_d;
  logic [LEN_W-1:0]       byte_cnt, byte_cnt_d;
  logic [NIB_W-1:0]       lo_nib, lo_nib_d;
  logic                   ovl, ovl_d;
  logic [BYTE_W-1:0]      byte_data_d;
  logic                   byte_valid_d, sof_d, eof_d, frame_err_d;
  logic [LEN_W-1:0]       frame_len_d;
  logic [CNT_W-1:0]       frame_cnt_d, err_cnt_d;
  logic                   fin_c, fin_err_c, abort_c, crc_bad_c;

`ifdef ETH_RX_FCS_CHECK_EN
  logic [CRC_W-1:0] crc_q;
  logic             crc_clear_c;

  assign crc_clear_c = (state == PRE) && (state_d == LO);

  crc32_d8 u_crc (
    .clk   (e_rxc),
    .reset (reset),
    .clear (crc_clear_c),
    .en    (byte_valid_d),
    .data  (byte_data_d),
    .crc   (crc_q)
  );

  assign crc_bad_c = (bitrev32(crc_q) != CRC32_RESIDUE) || (byte_cnt < LEN_W'(4));
`else
  assign crc_bad_c = 1'b0;
`endif

  // Single input register stage; cleared so a nibble seen during reset is dropped.
  always_ff @(posedge e_rxc) begin
    if (reset) begin
      rxdv_q <= 1'b0;
      rxd_q  <= '0;
    end else begin
      rxdv_q <= e_rxdv;
      rxd_q  <= e_rxd;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge e_rxc) begin
    if (reset) begin
      state      <= IDLE;
      pre_cnt    <= '0;
      byte_cnt   <= '0;
      lo_nib     <= '0;
      ovl        <= 1'b0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      sof        <= 1'b0;
      eof        <= 1'b0;
      frame_err  <= 1'b0;
      frame_len  <= '0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      state      <= state_d;
      pre_cnt    <= pre_cnt_d;
      byte_cnt   <= byte_cnt_d;
      lo_nib     <= lo_nib_d;
      ovl        <= ovl_d;
      byte_data  <= byte_data_d;
      byte_valid <= byte_valid_d;
      sof        <= sof_d;
      eof        <= eof_d;
      frame_err  <= frame_err_d;
      frame_len  <= frame_len_d;
      frame_cnt  <= frame_cnt_d;
      err_cnt    <= err_cnt_d;
    end
  end

  // Next-state, next-output and counter logic.
  always_comb begin
    state_d      = state;
    pre_cnt_d    = pre_cnt;
    byte_cnt_d   = byte_cnt;
    lo_nib_d     = lo_nib;
    ovl_d        = ovl;
    byte_data_d  = byte_data;
    byte_valid_d = 1'b0;
    sof_d        = 1'b0;
    eof_d        = 1'b0;
    frame_err_d  = 1'b0;
    frame_len_d  = frame_len;
    frame_cnt_d  = frame_cnt;
    err_cnt_d    = err_cnt;
    fin_c        = 1'b0;
    fin_err_c    = 1'b0;
    abort_c      = 1'b0;

    case (state)
      // EOF behaves like IDLE so a preamble can start on the gap cycle.
      IDLE, EOF: begin
        state_d = IDLE;
        if (rxdv_q) begin
          if (rxd_q == PRE_NIBBLE) begin
            state_d   = PRE;
            pre_cnt_d = PRE_CNT_W'(1);
          end else begin
            state_d = DROP;
            abort_c = 1'b1;
          end
        end
      end
      PRE: begin
        if (!rxdv_q) begin
          state_d = IDLE;
          abort_c = 1'b1;
        end else if (rxd_q == PRE_NIBBLE) begin
          if (pre_cnt != '1) pre_cnt_d = pre_cnt + PRE_CNT_W'(1);
        end else if ((rxd_q == SFD_NIBBLE) && (32'(pre_cnt) >= MIN_PRE_NIBBLES)) begin
          state_d    = LO;
          byte_cnt_d = '0;
          ovl_d      = 1'b0;
        end else begin
          state_d = DROP;
          abort_c = 1'b1;
        end
      end
      LO: begin
        if (!rxdv_q) begin
          state_d   = EOF;
          fin_c     = 1'b1;
          fin_err_c = crc_bad_c;
        end else begin
          lo_nib_d = rxd_q;
          state_d  = HI;
        end
      end
      HI: begin
        if (!rxdv_q) begin
          // Odd nibble count: the partial byte is discarded.
          state_d   = EOF;
          fin_c     = 1'b1;
          fin_err_c = 1'b1;
        end else if (32'(byte_cnt) >= MAX_FRAME_BYTES) begin
          state_d = DROP;
          ovl_d   = 1'b1;
        end else begin
          byte_valid_d = 1'b1;
          byte_data_d  = {rxd_q, lo_nib};
          sof_d        = (byte_cnt == '0);
          byte_cnt_d   = byte_cnt + LEN_W'(1);
          state_d      = LO;
        end
      end
      DROP: begin
        if (!rxdv_q) begin
          if (ovl) begin
            state_d   = EOF;
            fin_c     = 1'b1;
            fin_err_c = 1'b1;
            ovl_d     = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (fin_c) begin
      eof_d       = 1'b1;
      frame_err_d = fin_err_c;
      frame_len_d = byte_cnt;
    end

    if (abort_c || (fin_c && fin_err_c)) begin
      if (err_cnt != '1) err_cnt_d = err_cnt + CNT_W'(1);
    end else if (fin_c) begin
      if (frame_cnt != '1) frame_cnt_d = frame_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mii_rx_byte_assembler.sv
// Directed bench for mii_rx_byte_assembler; a second instance with a
// 16-byte limit covers truncation.
module tb_mii_rx_byte_assembler;

`ifdef ETH_RX_FCS_CHECK_EN
  localparam bit FCS_ON = 1'b1;
`else
  localparam bit FCS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rxdv = 1'b0;
  logic [3:0]  rxd = 4'h0;

  logic [7:0]  byte_data, s_byte_data;
  logic        byte_valid, sof, eof, frame_err;
  logic        s_byte_valid, s_sof, s_eof, s_frame_err;
  logic [15:0] frame_len, frame_cnt, err_cnt;
  logic [15:0] s_frame_len, s_frame_cnt, s_err_cnt;

  int checks = 0;
  int failures = 0;

  byte unsigned q_data[$];
  bit           q_sof[$];
  int n_eof, eof_cyc, fall_cyc, cyc;
  logic eof_err;
  logic [15:0] eof_len;
  int s_nbytes, s_neof;
  logic s_err;
  logic [15:0] s_len;
  logic prev_dv = 1'b0;
  int ef = 0;
  int ee = 0;

  always #5 clk = ~clk;

  mii_rx_byte_assembler dut (
    .e_rxc(clk), .reset(reset), .e_rxdv(rxdv), .e_rxd(rxd),
    .byte_data(byte_data), .byte_valid(byte_valid), .sof(sof), .eof(eof),
    .frame_err(frame_err), .frame_len(frame_len),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  mii_rx_byte_assembler #(.MAX_FRAME_BYTES(16)) dut_s (
    .e_rxc(clk), .reset(reset), .e_rxdv(rxdv), .e_rxd(rxd),
    .byte_data(s_byte_data), .byte_valid(s_byte_valid), .sof(s_sof), .eof(s_eof),
    .frame_err(s_frame_err), .frame_len(s_frame_len),
    .frame_cnt(s_frame_cnt), .err_cnt(s_err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    cyc++;
    if (byte_valid) begin
      q_data.push_back(byte_data);
      q_sof.push_back(sof);
    end
    if (eof) begin
      n_eof++;
      eof_err = frame_err;
      eof_len = frame_len;
      eof_cyc = cyc;
      chk("eof_without_byte", 32'(byte_valid), 32'd0);
    end
    if (s_byte_valid) s_nbytes++;
    if (s_eof) begin
      s_neof++;
      s_err = s_frame_err;
      s_len = s_frame_len;
    end
  endtask

  task automatic step(input logic dv, input logic [3:0] d);
    rxdv = dv;
    rxd  = d;
    @(posedge clk);
    #1;
    sample();
    if (prev_dv && !dv) fall_cyc = cyc;
    prev_dv = dv;
  endtask

  task automatic clr();
    q_data.delete();
    q_sof.delete();
    n_eof = 0; eof_err = 1'bx; eof_len = 'x;
    s_nbytes = 0; s_neof = 0; s_err = 1'bx; s_len = 'x;
  endtask

  task automatic send_pre(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 4'h5);
    step(1'b1, 4'hD);
  endtask

  task automatic send_byte(input logic [7:0] b);
    step(1'b1, b[3:0]);
    step(1'b1, b[7:4]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0);
  endtask

  // Number of captured bytes that differ from base, base+1, ...
  function automatic int data_bad(input int base);
    int bad = 0;
    for (int i = 0; i < q_data.size(); i++) begin
      if (q_data[i] != 8'(base + i)) bad++;
    end
    return bad;
  endfunction

  function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  initial begin
    logic [31:0] s_err0;
    logic [31:0] fcs;
    clr();
    cyc = 0; fall_cyc = 0; eof_cyc = 0;

    // Reset values
    idle(3);
    chk("rst_byte_valid", 32'(byte_valid), 32'd0);
    chk("rst_sof",        32'(sof),        32'd0);
    chk("rst_eof",        32'(eof),        32'd0);
    chk("rst_frame_err",  32'(frame_err),  32'd0);
    chk("rst_byte_data",  32'(byte_data),  32'd0);
    chk("rst_frame_len",  32'(frame_len),  32'd0);
    chk("rst_frame_cnt",  32'(frame_cnt),  32'd0);
    chk("rst_err_cnt",    32'(err_cnt),    32'd0);
    reset = 1'b0;
    idle(2);

    // Nominal 64-byte frame
    clr();
    send_pre(15);
    for (int i = 0; i < 64; i++) send_byte(8'(i));
    idle(4);
    if (FCS_ON) ee++; else ef++;
    chk("nom_nbytes",    32'(q_data.size()), 32'd64);
    chk("nom_data",      32'(data_bad(0)),   32'd0);
    chk("nom_sof_first", 32'(q_sof[0]),      32'd1);
    chk("nom_sof_count", 32'(q_sof.sum() with (int'(item))), 32'd1);
    chk("nom_neof",      32'(n_eof),         32'd1);
    chk("nom_eof_lat",   32'(eof_cyc - fall_cyc), 32'd1);
    chk("nom_len",       32'(eof_len),       32'd64);
    chk("nom_err",       32'(eof_err),       32'(FCS_ON));
    chk("nom_frame_cnt", 32'(frame_cnt),     32'(ef));
    chk("nom_err_cnt",   32'(err_cnt),       32'(ee));

    // Dribble nibble
    clr();
    send_pre(15);
    for (int i = 0; i < 64; i++) send_byte(8'(i));
    step(1'b1, 4'hA);
    idle(4);
    ee++;
    chk("drb_nbytes",    32'(q_data.size()), 32'd64);
    chk("drb_neof",      32'(n_eof),         32'd1);
    chk("drb_err",       32'(eof_err),       32'd1);
    chk("drb_len",       32'(eof_len),       32'd64);
    chk("drb_err_cnt",   32'(err_cnt),       32'(ee));
    chk("drb_frame_cnt", 32'(frame_cnt),     32'(ef));

    // Short preamble (4 nibbles)
    clr();
    send_pre(4);
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    idle(3);
    ee++;
    chk("spre_nbytes",  32'(q_data.size()), 32'd0);
    chk("spre_neof",    32'(n_eof),         32'd0);
    chk("spre_err_cnt", 32'(err_cnt),       32'(ee));

    // One nibble below the minimum
    clr();
    send_pre(7);
    send_byte(8'h11);
    idle(3);
    ee++;
    chk("pre7_nbytes",  32'(q_data.size()), 32'd0);
    chk("pre7_err_cnt", 32'(err_cnt),       32'(ee));

    // e_rxdv drops inside the preamble
    clr();
    for (int i = 0; i < 3; i++) step(1'b1, 4'h5);
    idle(3);
    ee++;
    chk("pabort_neof",    32'(n_eof),   32'd0);
    chk("pabort_err_cnt", 32'(err_cnt), 32'(ee));

    // 20-byte frame: full on the default instance, truncated at 16 on the other
    clr();
    s_err0 = 32'(s_err_cnt);
    send_pre(15);
    for (int i = 0; i < 20; i++) send_byte(8'(8'h80 + i));
    idle(4);
    if (FCS_ON) ee++; else ef++;
    chk("ovl_full_nbytes", 32'(q_data.size()), 32'd20);
    chk("ovl_full_data",   32'(data_bad(8'h80)), 32'd0);
    chk("ovl_full_len",    32'(eof_len),       32'd20);
    chk("ovl_s_nbytes",    32'(s_nbytes),      32'd16);
    chk("ovl_s_neof",      32'(s_neof),        32'd1);
    chk("ovl_s_err",       32'(s_err),         32'd1);
    chk("ovl_s_len",       32'(s_len),         32'd16);
    chk("ovl_s_err_cnt",   32'(s_err_cnt),     s_err0 + 32'd1);

    // Back-to-back frames with a single idle cycle and minimum preamble
    clr();
    send_pre(8);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h20 + i));
    step(1'b0, 4'h0);
    send_pre(8);
    for (int i = 8; i < 16; i++) send_byte(8'(8'h20 + i));
    idle(4);
    if (FCS_ON) ee += 2; else ef += 2;
    chk("b2b_nbytes",    32'(q_data.size()), 32'd16);
    chk("b2b_data",      32'(data_bad(8'h20)), 32'd0);
    chk("b2b_sof_count", 32'(q_sof.sum() with (int'(item))), 32'd2);
    chk("b2b_neof",      32'(n_eof),         32'd2);
    chk("b2b_len",       32'(eof_len),       32'd8);
    chk("b2b_frame_cnt", 32'(frame_cnt),     32'(ef));
    chk("b2b_err_cnt",   32'(err_cnt),       32'(ee));

`ifdef ETH_RX_FCS_CHECK_EN
    // Good and corrupted FCS
    for (int pass = 0; pass < 2; pass++) begin
      clr();
      fcs = 32'hFFFFFFFF;
      for (int i = 0; i < 60; i++) fcs = crc_ref(fcs, 8'(i));
      fcs = ~fcs;
      send_pre(15);
      for (int i = 0; i < 60; i++) send_byte((pass == 1 && i == 5) ? 8'(i ^ 1) : 8'(i));
      for (int k = 0; k < 4; k++) send_byte(fcs[8*k +: 8]);
      idle(4);
      if (pass == 0) ef++; else ee++;
      chk("fcs_neof",      32'(n_eof),     32'd1);
      chk("fcs_len",       32'(eof_len),   32'd64);
      chk("fcs_err",       32'(eof_err),   32'(pass));
      chk("fcs_err_cnt",   32'(err_cnt),   32'(ee));
      chk("fcs_frame_cnt", 32'(frame_cnt), 32'(ef));
    end
`endif

    // Reset in the middle of a frame
    clr();
    send_pre(8);
    for (int i = 0; i < 3; i++) send_byte(8'(8'h40 + i));
    reset = 1'b1;
    step(1'b1, 4'h3);
    step(1'b1, 4'h4);
    chk("mrst_byte_valid", 32'(byte_valid), 32'd0);
    chk("mrst_byte_data",  32'(byte_data),  32'd0);
    chk("mrst_frame_len",  32'(frame_len),  32'd0);
    chk("mrst_frame_cnt",  32'(frame_cnt),  32'd0);
    chk("mrst_err_cnt",    32'(err_cnt),    32'd0);
    reset = 1'b0;
    idle(6);
    chk("mrst_neof",       32'(n_eof),      32'd0);
    chk("mrst_err_cnt2",   32'(err_cnt),    32'd0);
    chk("mrst_frame_cnt2", 32'(frame_cnt),  32'd0);
    chk("mrst_frame_err",  32'(frame_err),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
